// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 streaming multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam int MUX_MAX_CH = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Rotate-priority encoder: grants the first request at or above the pointer,
// wrapping from NUM_CH-1 back to 0. Purely combinational; pointer lives in the parent.
module rr_arbiter_n
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] request,
    input  logic [SEL_W-1:0]  pointer,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [2*NUM_CH-1:0] doubled;
    logic [NUM_CH-1:0]   rotated;
    int                  offset;
    int                  winner;

    // Rotating a doubled copy puts the pointer channel at bit 0, so the lowest
    // set bit of the rotated vector is the nearest request at or above the pointer.
    always_comb begin
        doubled   = {request, request} >> pointer;
        rotated   = doubled[NUM_CH-1:0];
        offset    = -1;
        winner    = 0;
        grant     = '0;
        grant_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = k;
            end
        end
        if (offset >= 0) begin
            winner = (int'(pointer) + offset) % NUM_CH;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i == winner) begin
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// N:1 stream multiplexer with valid/ready per channel, fixed or round-robin select, one output register.
// Optional MUX_TRISTATE_OUT_EN: MUX_Data_Out floats to Z while Enable_In is low.
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = clog2(NUM_CH)
) (
    input  logic                     Clock_In,
    input  logic                     Reset_In,
    input  logic                     Enable_In,
    input  logic                     Mode_In,
    input  logic [SEL_W-1:0]         Select_In,
    input  logic [NUM_CH*DATA_W-1:0] Data_In,
    input  logic [NUM_CH-1:0]        Valid_In,
    output logic [NUM_CH-1:0]        Ready_Out,
    output logic [DATA_W-1:0]        MUX_Data_Out,
    output logic                     MUX_Valid_Out,
    input  logic                     MUX_Ready_In,
    output logic [SEL_W-1:0]         Grant_Out
);

    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [SEL_W-1:0]  grant_q;
    logic [SEL_W-1:0]  rr_ptr_q;

    logic [NUM_CH-1:0] rr_grant;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_CH-1:0] fixed_onehot;
    logic [NUM_CH-1:0] cand_onehot;
    logic [SEL_W-1:0]  cand_idx;
    logic [DATA_W-1:0] cand_data;
    logic              mode_is_rr;
    logic              stage_free;
    logic              xfer_in;
    logic              xfer_out;
    logic [SEL_W-1:0]  rr_ptr_next;

    rr_arbiter_n #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arbiter (
        .request   (Valid_In),
        .pointer   (rr_ptr_q),
        .grant     (rr_grant),
        .grant_idx (rr_idx)
    );

    assign mode_is_rr = (Mode_In == MODE_RR);
    assign stage_free = !valid_q || MUX_Ready_In;
    assign xfer_out   = valid_q && MUX_Ready_In;

    // An out-of-range fixed select matches no bit, which leaves no candidate.
    always_comb begin
        fixed_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(Select_In) == i) begin
                fixed_onehot[i] = 1'b1;
            end
        end
    end

    assign cand_onehot = mode_is_rr ? rr_grant : fixed_onehot;
    assign cand_idx    = mode_is_rr ? rr_idx : Select_In;
    assign Ready_Out   = (Enable_In && stage_free) ? cand_onehot : '0;
    assign xfer_in     = |(Valid_In & Ready_Out);

    always_comb begin
        cand_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cand_onehot[i]) begin
                cand_data = Data_In[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_next = (cand_idx == SEL_W'(NUM_CH - 1)) ? '0 : cand_idx + 1'b1;

    // A new beat takes priority over draining, giving one beat per cycle under flow.
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else if (xfer_in) begin
            data_q  <= cand_data;
            valid_q <= 1'b1;
            grant_q <= cand_idx;
            if (mode_is_rr) begin
                rr_ptr_q <= rr_ptr_next;
            end
        end else if (xfer_out) begin
            valid_q <= 1'b0;
        end
    end

    assign MUX_Valid_Out = valid_q;
    assign Grant_Out     = grant_q;

`ifdef MUX_TRISTATE_OUT_EN
    assign MUX_Data_Out = Enable_In ? data_q : {DATA_W{1'bz}};
`else
    assign MUX_Data_Out = data_q;
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed self-checking bench for mux_n_1_stream (4-channel instance plus a 3-channel one
// for the out-of-range select case). Honours MUX_TRISTATE_OUT_EN when it is defined.
module tb_mux_n_1_stream;

    logic        Clock_In = 1'b0;
    logic        Reset_In;

    logic        Enable_In;
    logic        Mode_In;
    logic [1:0]  Select_In;
    logic [31:0] Data_In;
    logic [3:0]  Valid_In;
    logic [3:0]  Ready_Out;
    logic [7:0]  MUX_Data_Out;
    logic        MUX_Valid_Out;
    logic        MUX_Ready_In;
    logic [1:0]  Grant_Out;

    logic        sm_enable;
    logic        sm_mode;
    logic [1:0]  sm_select;
    logic [23:0] sm_data;
    logic [2:0]  sm_valid;
    logic [2:0]  sm_ready_out;
    logic [7:0]  sm_mux_data;
    logic        sm_mux_valid;
    logic        sm_mux_ready;
    logic [1:0]  sm_grant;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [7:0]  chData [4];
    logic [31:0] heldExp;
    int          rrSeqA [5] = '{0, 1, 2, 3, 0};
    int          rrSeqB [4] = '{1, 3, 1, 3};

    mux_n_1_stream #(.NUM_CH(4), .DATA_W(8)) dut (
        .Clock_In      (Clock_In),
        .Reset_In      (Reset_In),
        .Enable_In     (Enable_In),
        .Mode_In       (Mode_In),
        .Select_In     (Select_In),
        .Data_In       (Data_In),
        .Valid_In      (Valid_In),
        .Ready_Out     (Ready_Out),
        .MUX_Data_Out  (MUX_Data_Out),
        .MUX_Valid_Out (MUX_Valid_Out),
        .MUX_Ready_In  (MUX_Ready_In),
        .Grant_Out     (Grant_Out)
    );

    mux_n_1_stream #(.NUM_CH(3), .DATA_W(8)) dut_small (
        .Clock_In      (Clock_In),
        .Reset_In      (Reset_In),
        .Enable_In     (sm_enable),
        .Mode_In       (sm_mode),
        .Select_In     (sm_select),
        .Data_In       (sm_data),
        .Valid_In      (sm_valid),
        .Ready_Out     (sm_ready_out),
        .MUX_Data_Out  (sm_mux_data),
        .MUX_Valid_Out (sm_mux_valid),
        .MUX_Ready_In  (sm_mux_ready),
        .Grant_Out     (sm_grant)
    );

    always #5 Clock_In = ~Clock_In;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic mode, input logic [1:0] sel,
                                 input logic [3:0] valid, input logic rdy);
        Enable_In    = en;
        Mode_In      = mode;
        Select_In    = sel;
        Valid_In     = valid;
        MUX_Ready_In = rdy;
        Data_In      = {chData[3], chData[2], chData[1], chData[0]};
    endtask

    task automatic tick();
        @(posedge Clock_In);
        #2;
    endtask

    initial begin
        chData = '{8'h10, 8'h21, 8'h3C, 8'h4B};
        Reset_In = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        sm_enable = 1'b0; sm_mode = 1'b0; sm_select = 2'd0;
        sm_data = {8'hC3, 8'hB2, 8'hA1}; sm_valid = 3'b000; sm_mux_ready = 1'b0;
        #3;
        checkOutput("reset_valid", 32'(MUX_Valid_Out), 32'd0);
        checkOutput("reset_data",  32'(MUX_Data_Out),  32'd0);
        checkOutput("reset_grant", 32'(Grant_Out),     32'd0);
        tick();
        Reset_In = 1'b0;
        tick();

        // Fixed select of channel 2
        applyStimulus(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1);
        #1;
        checkOutput("fixed_ready", 32'(Ready_Out), 32'b0100);
        tick();
        checkOutput("fixed_data",  32'(MUX_Data_Out),  32'h3C);
        checkOutput("fixed_grant", 32'(Grant_Out),     32'd2);
        checkOutput("fixed_valid", 32'(MUX_Valid_Out), 32'd1);

        // Asynchronous reset while 0xA5 is held
        chData[2] = 8'hA5;
        applyStimulus(1'b1, 1'b0, 2'd2, 4'b1111, 1'b1);
        tick();
        checkOutput("midrst_pre_data", 32'(MUX_Data_Out), 32'hA5);
        Reset_In = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(MUX_Valid_Out), 32'd0);
        checkOutput("midrst_data",  32'(MUX_Data_Out),  32'd0);
        checkOutput("midrst_grant", 32'(Grant_Out),     32'd0);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        #1;
        Reset_In = 1'b0;
        tick();

        // Round-robin, all channels requesting
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
        #1;
        checkOutput("rr_ready_ptr0", 32'(Ready_Out), 32'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("rr_all_grant%0d", i), 32'(Grant_Out), 32'(rrSeqA[i]));
            checkOutput($sformatf("rr_all_data%0d", i), 32'(MUX_Data_Out), 32'(chData[rrSeqA[i]]));
            checkOutput($sformatf("rr_all_valid%0d", i), 32'(MUX_Valid_Out), 32'd1);
        end

        // Round-robin, only channels 1 and 3 requesting
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("rr_sparse_grant%0d", i), 32'(Grant_Out), 32'(rrSeqB[i]));
            checkOutput($sformatf("rr_sparse_data%0d", i), 32'(MUX_Data_Out), 32'(chData[rrSeqB[i]]));
        end

        // Back-pressure holding 0x11
        chData[1] = 8'h11;
        applyStimulus(1'b1, 1'b0, 2'd1, 4'b1111, 1'b1);
        tick();
        checkOutput("bp_load_data", 32'(MUX_Data_Out), 32'h11);
        chData[1] = 8'h22;
        applyStimulus(1'b1, 1'b0, 2'd1, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("bp_hold_data%0d", i), 32'(MUX_Data_Out), 32'h11);
            checkOutput($sformatf("bp_hold_valid%0d", i), 32'(MUX_Valid_Out), 32'd1);
            checkOutput($sformatf("bp_ready%0d", i), 32'(Ready_Out), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 2'd1, 4'b1111, 1'b1);
        #1;
        checkOutput("bp_release_ready", 32'(Ready_Out), 32'b0010);
        tick();
        checkOutput("bp_next_data",  32'(MUX_Data_Out),  32'h22);
        checkOutput("bp_next_valid", 32'(MUX_Valid_Out), 32'd1);

        // Enable low: held 0x22 drains, nothing new accepted, pointer untouched
`ifdef MUX_TRISTATE_OUT_EN
        heldExp = {24'h0, 8'hzz};
`else
        heldExp = 32'h22;
`endif
        applyStimulus(1'b1, 1'b0, 2'd1, 4'b1111, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b0);
        #1;
        checkOutput("en_off_ready", 32'(Ready_Out), 32'd0);
        checkOutput("en_off_data",  32'(MUX_Data_Out), heldExp);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'b1111, 1'b1);
        #1;
        checkOutput("en_off_ready_free", 32'(Ready_Out), 32'd0);
        tick();
        checkOutput("en_off_drain_valid", 32'(MUX_Valid_Out), 32'd0);
        checkOutput("en_off_drain_data",  32'(MUX_Data_Out),  heldExp);
        tick();
        checkOutput("en_off_idle_valid", 32'(MUX_Valid_Out), 32'd0);
        applyStimulus(1'b1, 1'b1, 2'd0, 4'b1111, 1'b1);
        #1;
        checkOutput("en_on_data",      32'(MUX_Data_Out), 32'h22);
        checkOutput("en_on_ready_ptr", 32'(Ready_Out),    32'b0001);
        tick();
        checkOutput("en_on_grant", 32'(Grant_Out),     32'd0);
        checkOutput("en_on_beat",  32'(MUX_Data_Out),  32'h10);
        checkOutput("en_on_valid", 32'(MUX_Valid_Out), 32'd1);

        // Three-channel instance with an out-of-range select
        sm_enable = 1'b1; sm_mode = 1'b0; sm_select = 2'd3;
        sm_valid = 3'b111; sm_mux_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("sel_oor_ready%0d", i), 32'(sm_ready_out), 32'd0);
            tick();
            checkOutput($sformatf("sel_oor_valid%0d", i), 32'(sm_mux_valid), 32'd0);
        end
        sm_select = 2'd2;
        #1;
        checkOutput("sel_ok_ready", 32'(sm_ready_out), 32'b100);
        tick();
        checkOutput("sel_ok_data",  32'(sm_mux_data), 32'hC3);
        checkOutput("sel_ok_grant", 32'(sm_grant),    32'd2);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
